// File: rtl/usb_pkg.sv
// usb_pkg: shared types and timing defaults for the USB transmit-side blocks.
package usb_pkg;
    localparam int CNT_W           = 14;
    localparam int IPD_CLKS_DEF    = 20;
    localparam int WINDOW_CLKS_DEF = 75;
    localparam int MAX_TX_CLKS_DEF = 12000;
    typedef enum logic [2:0] {IDLE, WAIT_IPD, ARB, DRIVE_ACK, DRIVE_DESC} state_t;
endpackage

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: grants the line driver to the ACK or descriptor responder after
// the inter-packet delay, with a response window and a transmit watchdog.
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int IPD_CLKS    = IPD_CLKS_DEF,
    parameter int WINDOW_CLKS = WINDOW_CLKS_DEF,
    parameter int MAX_TX_CLKS = MAX_TX_CLKS_DEF
) (
    input  logic useClk,
    input  logic reset,
    input  logic detectEop,
    input  logic reqAck,
    input  logic reqDesc,
    input  logic txDone,
    output logic grantAck,
    output logic grantDesc,
    output logic OE,
    output logic busy,
    output logic txTimeout
);
    state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic ipd_done, win_done, tx_max, driving;
    logic next_grant_ack, next_grant_desc, next_busy, next_timeout;

    assign ipd_done = cnt == CNT_W'(IPD_CLKS - 1);
    assign win_done = cnt == CNT_W'(WINDOW_CLKS - 1);
    assign tx_max   = cnt == CNT_W'(MAX_TX_CLKS - 1);
    assign driving  = state == DRIVE_ACK || state == DRIVE_DESC;

    // Outputs are registered from the next state so grants rise on the entering edge.
    always_ff @(posedge useClk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grantAck  <= 1'b0;
            grantDesc <= 1'b0;
            OE        <= 1'b0;
            busy      <= 1'b0;
            txTimeout <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= (next_state != state) ? '0 : (cnt != '1) ? cnt + 1'b1 : cnt;
            grantAck  <= next_grant_ack;
            grantDesc <= next_grant_desc;
            OE        <= next_grant_ack | next_grant_desc;
            busy      <= next_busy;
            txTimeout <= next_timeout;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:                  if (detectEop) next_state = WAIT_IPD;
            WAIT_IPD:              if (ipd_done) next_state = ARB;
            ARB:                   next_state = reqAck ? DRIVE_ACK : reqDesc ? DRIVE_DESC : win_done ? IDLE : ARB;
            DRIVE_ACK, DRIVE_DESC: if (txDone || tx_max) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    always_comb begin
        next_grant_ack  = next_state == DRIVE_ACK;
        next_grant_desc = next_state == DRIVE_DESC;
        next_busy       = next_state != IDLE;
        next_timeout    = driving && tx_max && !txDone;
    end
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed checks of grant timing, priority, window, watchdog and reset.
module tb_usb_tx_arbiter;
    logic useClk = 1'b0;
    logic reset = 1'b1;
    logic detectEop = 1'b0, reqAck = 1'b0, reqDesc = 1'b0, txDone = 1'b0;
    logic grantAck, grantDesc, OE, busy, txTimeout;
    int checks = 0, errors = 0, cyc = 0;

    usb_tx_arbiter dut (
        .useClk(useClk), .reset(reset), .detectEop(detectEop), .reqAck(reqAck),
        .reqDesc(reqDesc), .txDone(txDone), .grantAck(grantAck), .grantDesc(grantDesc),
        .OE(OE), .busy(busy), .txTimeout(txTimeout)
    );

    always #4 useClk = ~useClk;

    task automatic tick();
        @(posedge useClk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // Leaves the bench in cycle 1, i.e. the first WAIT_IPD cycle.
    task automatic start_packet();
        cyc = 0;
        detectEop = 1'b1;
        tick();
        detectEop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks += 5;
        if (grantAck !== 1'b0) begin errors++; $display("FAIL reset_grantAck: got %b expected 0", grantAck); end
        if (grantDesc !== 1'b0) begin errors++; $display("FAIL reset_grantDesc: got %b expected 0", grantDesc); end
        if (OE !== 1'b0) begin errors++; $display("FAIL reset_OE: got %b expected 0", OE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (txTimeout !== 1'b0) begin errors++; $display("FAIL reset_txTimeout: got %b expected 0", txTimeout); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ack_latency();
        start_packet();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_ipd: got %b expected 1", busy); end
        if (OE !== 1'b0) begin errors++; $display("FAIL lat_oe_ipd: got %b expected 0", OE); end
        wait_cyc(5);
        reqAck = 1'b1;
        wait_cyc(21);
        checks += 2;
        if (grantAck !== 1'b0) begin errors++; $display("FAIL lat_grant_c21: got %b expected 0", grantAck); end
        if (OE !== 1'b0) begin errors++; $display("FAIL lat_oe_c21: got %b expected 0", OE); end
        wait_cyc(22);
        checks += 3;
        if (grantAck !== 1'b1) begin errors++; $display("FAIL lat_grant_c22: got %b expected 1", grantAck); end
        if (OE !== 1'b1) begin errors++; $display("FAIL lat_oe_c22: got %b expected 1", OE); end
        if (grantDesc !== 1'b0) begin errors++; $display("FAIL lat_desc_c22: got %b expected 0", grantDesc); end
        reqAck = 1'b0;
        wait_cyc(100);
        checks++;
        if (OE !== 1'b1) begin errors++; $display("FAIL lat_oe_c100: got %b expected 1", OE); end
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        checks += 3;
        if (OE !== 1'b0) begin errors++; $display("FAIL lat_oe_c101: got %b expected 0", OE); end
        if (grantAck !== 1'b0) begin errors++; $display("FAIL lat_grant_c101: got %b expected 0", grantAck); end
        if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_c101: got %b expected 0", busy); end
    endtask

    task automatic test_priority();
        logic seen;
        start_packet();
        reqAck = 1'b1;
        reqDesc = 1'b1;
        wait_cyc(22);
        checks += 2;
        if (grantAck !== 1'b1) begin errors++; $display("FAIL prio_ack: got %b expected 1", grantAck); end
        if (grantDesc !== 1'b0) begin errors++; $display("FAIL prio_desc: got %b expected 0", grantDesc); end
        reqAck = 1'b0;
        tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        seen = 1'b0;
        repeat (150) begin
            tick();
            seen |= grantDesc | OE | busy;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL prio_no_desc_without_eop: got %b expected 0", seen); end
        start_packet();
        wait_cyc(22);
        checks += 3;
        if (grantDesc !== 1'b1) begin errors++; $display("FAIL prio_desc_later: got %b expected 1", grantDesc); end
        if (grantAck !== 1'b0) begin errors++; $display("FAIL prio_ack_later: got %b expected 0", grantAck); end
        if (OE !== 1'b1) begin errors++; $display("FAIL prio_oe_later: got %b expected 1", OE); end
        reqDesc = 1'b0;
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b expected 0", busy); end
    endtask

    task automatic test_window();
        int n;
        logic g;
        start_packet();
        n = 0;
        g = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            n++;
            g |= OE | grantAck | grantDesc;
            tick();
        end
        checks += 2;
        if (n != 95) begin errors++; $display("FAIL window_busy_cycles: got %0d expected 95", n); end
        if (g !== 1'b0) begin errors++; $display("FAIL window_no_grant: got %b expected 0", g); end
    endtask

    task automatic test_timeout();
        int n;
        start_packet();
        reqDesc = 1'b1;
        wait_cyc(22);
        checks++;
        if (grantDesc !== 1'b1) begin errors++; $display("FAIL wd_grant: got %b expected 1", grantDesc); end
        reqDesc = 1'b0;
        n = 0;
        for (int i = 0; i < 13000 && OE; i++) begin
            n++;
            if (txTimeout) begin errors++; $display("FAIL wd_early_pulse: got 1 expected 0 at drive cycle %0d", n); end
            tick();
        end
        checks += 4;
        if (n != 12000) begin errors++; $display("FAIL wd_oe_cycles: got %0d expected 12000", n); end
        if (txTimeout !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b expected 1", txTimeout); end
        if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy: got %b expected 0", busy); end
        tick();
        if (txTimeout !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b expected 0", txTimeout); end
    endtask

    task automatic test_reset_mid_drive();
        logic seen;
        start_packet();
        reqAck = 1'b1;
        wait_cyc(22);
        checks++;
        if (grantAck !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got %b expected 1", grantAck); end
        reset = 1'b1;
        tick();
        checks += 3;
        if (OE !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", OE); end
        if (grantAck !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", grantAck); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            tick();
            seen |= grantAck | OE | busy;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_grant_without_eop: got %b expected 0", seen); end
        reqAck = 1'b0;
    endtask

    task automatic test_eop_ignored();
        start_packet();
        wait_cyc(10);
        detectEop = 1'b1;
        tick();
        detectEop = 1'b0;
        reqDesc = 1'b1;
        wait_cyc(21);
        checks++;
        if (grantDesc !== 1'b0) begin errors++; $display("FAIL eop_c21: got %b expected 0", grantDesc); end
        wait_cyc(22);
        checks++;
        if (grantDesc !== 1'b1) begin errors++; $display("FAIL eop_c22: got %b expected 1", grantDesc); end
        reqDesc = 1'b0;
        wait_cyc(30);
        detectEop = 1'b1;
        tick();
        detectEop = 1'b0;
        checks += 3;
        if (grantDesc !== 1'b1) begin errors++; $display("FAIL eop_drive_grant: got %b expected 1", grantDesc); end
        if (OE !== 1'b1) begin errors++; $display("FAIL eop_drive_oe: got %b expected 1", OE); end
        if (busy !== 1'b1) begin errors++; $display("FAIL eop_drive_busy: got %b expected 1", busy); end
        wait_cyc(40);
        txDone = 1'b1;
        tick();
        checks += 3;
        if (OE !== 1'b0) begin errors++; $display("FAIL eop_done_oe: got %b expected 0", OE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL eop_done_busy: got %b expected 0", busy); end
        tick();
        txDone = 1'b0;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_txdone_ignored: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ack_latency();
        test_priority();
        test_window();
        test_timeout();
        test_reset_mid_drive();
        test_eop_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge useClk) begin
        if (grantAck && grantDesc) begin
            errors++;
            $display("FAIL mutual_grant: got both grants high expected at most one");
        end
    end
endmodule
